// File: rtl/swo_frame_packer.sv
// Packs the decoded SWO byte stream into 16-byte frames through a byte FIFO.
// A partial frame is padded and flushed after an idle timeout.
module swo_frame_packer #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned FLUSH_TICKS = 4096,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic         rst,
  input  logic         clk,
  input  logic         byteAvail,
  input  logic [7:0]   completeByte,
  output logic [127:0] frame,
  output logic [4:0]   frameLen,
  output logic         frameValid,
  input  logic         frameReady,
  output logic         overflow,
  output logic [15:0]  dropCount
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(FLUSH_TICKS);

  typedef enum logic {ASSEMBLE, HOLD} state_t;

  state_t         state;
  logic           armed;
  logic           prev_avail;
  logic [7:0]     mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  count;
  logic [3:0]     idx;
  logic [TW-1:0]  timer;

  logic strobe;
  logic pop;
  logic full;
  logic wr_ok;

  // The decoder's toggle line is not reset, so the first cycle only samples it.
  assign strobe = armed & (byteAvail ^ prev_avail);
  assign pop    = (state == ASSEMBLE) && (count != '0);
  assign full   = (count == PW'(DEPTH));
  assign wr_ok  = strobe && (!full || pop);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed      <= 1'b0;
      prev_avail <= 1'b0;
    end else begin
      armed      <= 1'b1;
      prev_avail <= byteAvail;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= completeByte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      dropCount <= '0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_ok, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
      overflow <= strobe & ~wr_ok;
      if (strobe && !wr_ok && dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ASSEMBLE;
      frame      <= '0;
      frameLen   <= '0;
      frameValid <= 1'b0;
      idx        <= '0;
      timer      <= '0;
    end else begin
      case (state)
        ASSEMBLE: begin
          if (pop) begin
            frame[{idx, 3'b000} +: 8] <= mem[rd_ptr[AW-1:0]];
            idx   <= idx + 4'd1;
            timer <= '0;
            if (idx == 4'd15) begin
              state      <= HOLD;
              frameValid <= 1'b1;
              frameLen   <= 5'd16;
            end
          end else if (idx != 4'd0) begin
            // Idle with a partial frame: flush it padded once the timeout expires.
            if (timer == TW'(FLUSH_TICKS - 1)) begin
              state      <= HOLD;
              frameValid <= 1'b1;
              frameLen   <= {1'b0, idx};
              for (int k = 0; k < 16; k++) begin
                if (k >= int'(idx)) frame[k*8 +: 8] <= PAD_BYTE;
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        HOLD: begin
          if (frameReady) begin
            state      <= ASSEMBLE;
            frameValid <= 1'b0;
            idx        <= '0;
            timer      <= '0;
          end
        end
        default: state <= ASSEMBLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swo_frame_packer.sv
// Directed bench for swo_frame_packer: full frames, idle flush, overflow,
// write-while-full-with-pop, reset with byteAvail high, reset during HOLD.
module tb_swo_frame_packer;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned FT    = 16;
  localparam logic [7:0]  PAD   = 8'hEE;

  logic         rst;
  logic         clk;
  logic         byteAvail;
  logic [7:0]   completeByte;
  logic [127:0] frame;
  logic [4:0]   frameLen;
  logic         frameValid;
  logic         frameReady;
  logic         overflow;
  logic [15:0]  dropCount;

  swo_frame_packer #(.DEPTH(DEPTH), .FLUSH_TICKS(FT), .PAD_BYTE(PAD)) dut (
    .rst(rst), .clk(clk), .byteAvail(byteAvail), .completeByte(completeByte),
    .frame(frame), .frameLen(frameLen), .frameValid(frameValid),
    .frameReady(frameReady), .overflow(overflow), .dropCount(dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int ovf_cnt = 0;
  logic [127:0] fq [$];
  logic [4:0]   lq [$];

  // Inputs change at posedge+2; the negedge sees exactly what the next posedge uses.
  always @(negedge clk) begin
    if (!rst && overflow) ovf_cnt++;
    if (!rst && frameValid && frameReady) begin
      fq.push_back(frame);
      lq.push_back(frameLen);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    step();
    completeByte = b;
    byteAvail    = ~byteAvail;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (fq.size() < n && c < budget) begin
      step();
      c++;
    end
    chk("frame_count", 128'(fq.size()), 128'(n));
  endtask

  // Expected frame of 16 bytes starting at value base+first.
  function automatic logic [127:0] seq_frame(input logic [7:0] base, input int first, input int len);
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[k*8 +: 8] = (k < len) ? 8'(int'(base) + first + k) : PAD;
    return f;
  endfunction

  initial begin
    byteAvail    = 1'b0;
    completeByte = 8'h00;
    frameReady   = 1'b1;
    do_reset();

    // Reset state
    chk("rst_frame", frame, '0);
    chk("rst_len", 128'(frameLen), 128'd0);
    chk("rst_valid", 128'(frameValid), 128'd0);
    chk("rst_ovf", 128'(overflow), 128'd0);
    chk("rst_drop", 128'(dropCount), 128'd0);

    // 1: full frame 0x00..0x0F, latency of frameValid after 16th pop
    for (int i = 0; i < 16; i++) send(8'(i));
    step();
    chk("t1_valid_before", 128'(frameValid), 128'd0);
    step();
    chk("t1_valid_after", 128'(frameValid), 128'd1);
    wait_frames(1, 20);
    chk("t1_frame", fq[0], 128'h0F0E0D0C0B0A09080706050403020100);
    chk("t1_len", 128'(lq[0]), 128'd16);
    fq.delete(); lq.delete();

    // 2: partial frame flushed with padding
    send(8'hA1); send(8'hA2); send(8'hA3);
    wait_frames(1, FT + 40);
    chk("t2_frame", fq[0], {{13{PAD}}, 24'hA3A2A1});
    chk("t2_len", 128'(lq[0]), 128'd3);
    fq.delete(); lq.delete();

    // 3: overflow with frameReady low
    frameReady = 1'b0;
    ovf_cnt    = 0;
    for (int i = 0; i < 16 + DEPTH + 5; i++) send(8'(8'h40 + i));
    idle(4);
    chk("t3_ovf_pulses", 128'(ovf_cnt), 128'd5);
    chk("t3_drop", 128'(dropCount), 128'd5);
    frameReady = 1'b1;
    wait_frames(3, 200);
    for (int j = 0; j < 3 && j < fq.size(); j++) begin
      chk($sformatf("t3_frame%0d", j), fq[j], seq_frame(8'h40, j*16, 16));
      chk($sformatf("t3_len%0d", j), 128'(lq[j]), 128'd16);
    end
    idle(FT + 20);
    chk("t3_no_extra", 128'(fq.size()), 128'd3);
    fq.delete(); lq.delete();

    // 5: write into a full FIFO in the cycle of a pop
    frameReady = 1'b0;
    ovf_cnt    = 0;
    for (int i = 0; i < 16 + DEPTH; i++) send(8'(8'h80 + i));
    step();
    frameReady = 1'b1;
    send(8'(8'h80 + 16 + DEPTH));
    wait_frames(4, 300);
    chk("t5_ovf_pulses", 128'(ovf_cnt), 128'd0);
    chk("t5_drop", 128'(dropCount), 128'd5);
    for (int j = 0; j < 3 && j < fq.size(); j++)
      chk($sformatf("t5_frame%0d", j), fq[j], seq_frame(8'h80, j*16, 16));
    if (fq.size() >= 4) begin
      chk("t5_last_frame", fq[3], seq_frame(8'h80, 48, 1));
      chk("t5_last_len", 128'(lq[3]), 128'd1);
    end
    fq.delete(); lq.delete();

    // 4: byteAvail held high through reset release
    byteAvail = 1'b1;
    do_reset();
    idle(FT + 20);
    chk("t4_valid", 128'(frameValid), 128'd0);
    chk("t4_no_frame", 128'(fq.size()), 128'd0);
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i));
    wait_frames(1, 40);
    chk("t4_frame", fq[0], seq_frame(8'h20, 0, 16));
    fq.delete(); lq.delete();

    // 6: reset while holding a frame with 8 bytes queued
    frameReady = 1'b0;
    for (int i = 0; i < 24; i++) send(8'(8'h60 + i));
    idle(3);
    chk("t6_hold_valid", 128'(frameValid), 128'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_frame", frame, '0);
    chk("t6_rst_valid", 128'(frameValid), 128'd0);
    chk("t6_rst_len", 128'(frameLen), 128'd0);
    chk("t6_rst_drop", 128'(dropCount), 128'd0);
    idle(2);
    rst        = 1'b0;
    frameReady = 1'b1;
    idle(FT + 20);
    chk("t6_no_frame", 128'(fq.size()), 128'd0);
    for (int i = 0; i < 16; i++) send(8'(8'hC0 + i));
    wait_frames(1, 40);
    chk("t6_frame", fq[0], seq_frame(8'hC0, 0, 16));
    idle(FT + 20);
    chk("t6_single", 128'(fq.size()), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
